// File: rtl/trigger_arbiter.sv
// Trigger arbiter: synchronizes eight asynchronous trigger lines and captures them as pending/lost flags.
// It offers one channel at a time round-robin over a valid/ready handshake, then waits a programmable holdoff.
module trigger_arbiter #(
    parameter int HOLDOFF_BITS = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [7:0]              trig_i,
    input  logic [7:0]              mask_i,
    input  logic [HOLDOFF_BITS-1:0] holdoff_i,
    input  logic                    lost_clear_i,
    input  logic                    trig_ready_i,
    output logic                    trig_valid_o,
    output logic [2:0]              trig_num_o,
    output logic [7:0]              pending_o,
    output logic [7:0]              lost_o,
    output logic                    busy_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [7:0]              s1_reg;
    logic [7:0]              s2_reg;
    logic [7:0]              s3_reg;
    logic [7:0]              pending_reg;
    logic [7:0]              lost_reg;
    logic [2:0]              last_grant_reg;
    logic [HOLDOFF_BITS-1:0] count_reg;

    logic [7:0] rise;
    logic [7:0] capture;
    logic [7:0] grant_clr;
    logic [7:0] pending_next;
    logic [7:0] lost_next;
    logic       accept;
    logic       sel_found;
    logic [2:0] sel_num;

    // s1/s2 resolve metastability; s3 holds the previous synchronized level for edge detection.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_reg <= '0;
            s2_reg <= '0;
            s3_reg <= '0;
        end else begin
            s1_reg <= trig_i;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    assign rise   = s2_reg & ~s3_reg;
    assign accept = trig_valid_o & trig_ready_i;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_chan
            assign capture[gi]   = rise[gi] & mask_i[gi];
            assign grant_clr[gi] = accept && (trig_num_o == 3'(gi));
            // A fresh rise wins over the clear caused by accepting the same channel.
            assign pending_next[gi] = !mask_i[gi]   ? 1'b0 :
                                      capture[gi]   ? 1'b1 :
                                      grant_clr[gi] ? 1'b0 : pending_reg[gi];
            assign lost_next[gi] = (capture[gi] & pending_reg[gi] & ~grant_clr[gi]) |
                                   (lost_reg[gi] & ~lost_clear_i);
        end
    endgenerate

    // Round-robin search starting just above the last granted channel.
    always_comb begin
        logic [2:0] idx;
        idx       = '0;
        sel_found = 1'b0;
        sel_num   = '0;
        for (int k = 1; k <= 8; k++) begin
            idx = last_grant_reg + 3'(k);
            if (!sel_found && pending_reg[idx]) begin
                sel_found = 1'b1;
                sel_num   = idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg      <= IDLE;
            trig_valid_o   <= 1'b0;
            trig_num_o     <= '0;
            last_grant_reg <= 3'd7;
            count_reg      <= '0;
            pending_reg    <= '0;
            lost_reg       <= '0;
        end else begin
            pending_reg <= pending_next;
            lost_reg    <= lost_next;
            case (state_reg)
                IDLE: begin
                    if (sel_found) begin
                        trig_num_o   <= sel_num;
                        trig_valid_o <= 1'b1;
                        state_reg    <= OFFER;
                    end
                end
                OFFER: begin
                    if (accept) begin
                        trig_valid_o   <= 1'b0;
                        last_grant_reg <= trig_num_o;
                        count_reg      <= holdoff_i;
                        state_reg      <= (holdoff_i == '0) ? IDLE : HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    count_reg <= count_reg - 1'b1;
                    if (count_reg == HOLDOFF_BITS'(1)) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    trig_valid_o <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o    = (state_reg != IDLE);
    assign pending_o = pending_reg;
    assign lost_o    = lost_reg;

endmodule

// File: tb/tb_trigger_arbiter.sv
// Bench for trigger_arbiter: directed scenarios plus randomized traffic against a cycle reference model;
// offered channels are queued by the model and popped by a monitor at each handshake.
module tb_trigger_arbiter;

    localparam int HB = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [7:0]    trig_i = '0;
    logic [7:0]    mask_i = 8'hFF;
    logic [HB-1:0] holdoff_i = '0;
    logic          lost_clear_i = 1'b0;
    logic          trig_ready_i = 1'b0;
    logic          trig_valid_o;
    logic [2:0]    trig_num_o;
    logic [7:0]    pending_o;
    logic [7:0]    lost_o;
    logic          busy_o;

    trigger_arbiter #(.HOLDOFF_BITS(HB)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .trig_i       (trig_i),
        .mask_i       (mask_i),
        .holdoff_i    (holdoff_i),
        .lost_clear_i (lost_clear_i),
        .trig_ready_i (trig_ready_i),
        .trig_valid_o (trig_valid_o),
        .trig_num_o   (trig_num_o),
        .pending_o    (pending_o),
        .lost_o       (lost_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    // Reference model: trigger levels seen at past edges, flag arrays, and an offer/deadtime phase.
    bit [7:0] m_seen1, m_seen2, m_seen3;
    bit [7:0] m_pend, m_lost;
    int       m_phase;   // 0 idle, 1 offering, 2 deadtime
    int       m_ch, m_last, m_hold;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_seen1 = '0; m_seen2 = '0; m_seen3 = '0;
        m_pend  = '0; m_lost  = '0;
        m_phase = 0;  m_ch = 0; m_last = 7; m_hold = 0;
        exp_q.delete();
    endtask

    // Advance the model across one rising edge using the inputs present at that edge.
    task automatic model_step();
        bit [7:0] rise_v, old_pend;
        bit       acc, en, granted, found;
        int       c;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rise_v   = m_seen2 & ~m_seen3;
        old_pend = m_pend;
        acc      = (m_phase == 1) && trig_ready_i;
        for (int i = 0; i < 8; i++) begin
            en      = rise_v[i] && mask_i[i];
            granted = acc && (m_ch == i);
            if (en && old_pend[i] && !granted) m_lost[i] = 1'b1;
            else if (lost_clear_i)             m_lost[i] = 1'b0;
            if (!mask_i[i])  m_pend[i] = 1'b0;
            else if (en)     m_pend[i] = 1'b1;
            else if (granted) m_pend[i] = 1'b0;
        end
        case (m_phase)
            0: begin
                found = 1'b0;
                for (int k = 1; k <= 8; k++) begin
                    c = (m_last + k) % 8;
                    if (!found && old_pend[c]) begin
                        found   = 1'b1;
                        m_ch    = c;
                        m_phase = 1;
                        exp_q.push_back(c);
                    end
                end
            end
            1: begin
                if (acc) begin
                    m_last  = m_ch;
                    m_hold  = int'(holdoff_i);
                    m_phase = (m_hold == 0) ? 0 : 2;
                end
            end
            default: begin
                if (m_hold == 1) m_phase = 0;
                m_hold--;
            end
        endcase
        m_seen3 = m_seen2;
        m_seen2 = m_seen1;
        m_seen1 = trig_i;
    endtask

    // Monitor: compare visible state and pop the scoreboard on every handshake.
    always @(negedge clk) begin
        check("pending_o", int'(pending_o), int'(m_pend));
        check("lost_o", int'(lost_o), int'(m_lost));
        check("busy_o", int'(busy_o), (m_phase != 0) ? 1 : 0);
        check("trig_valid_o", int'(trig_valid_o), (m_phase == 1) ? 1 : 0);
        if (m_phase == 1) check("trig_num_o", int'(trig_num_o), m_ch);
        if (rst_n && trig_valid_o && trig_ready_i) begin
            if (exp_q.size() == 0) begin
                check("grant_unexpected", int'(trig_num_o), -1);
            end else begin
                int e;
                e = exp_q.pop_front();
                check("grant_num", int'(trig_num_o), e);
                $display("grant ch=%0d expected=%0d t=%0t", trig_num_o, e, $time);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        model_step();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_valid", int'(trig_valid_o), 0);
        check("rst_busy", int'(busy_o), 0);
        steps(2);
        rst_n = 1'b1;
    endtask

    task automatic pulse(input logic [7:0] bits, input int off_cycles);
        trig_i = bits;
        steps(2);
        trig_i = '0;
        steps(off_cycles);
    endtask

    initial begin
        int first_v, nv, nb, cnt;
        int rs[3], ns[3];
        logic prev;

        model_reset();
        #1;
        hard_reset();
        check("reset_pending", int'(pending_o), 0);
        check("reset_lost", int'(lost_o), 0);

        // Single trigger on channel 5 with holdoff 4.
        mask_i = 8'hFF; holdoff_i = 4; trig_ready_i = 1'b1; trig_i = 8'h20;
        first_v = -1; nv = 0; nb = 0;
        for (int s = 1; s <= 14; s++) begin
            step();
            if (s == 2) trig_i = '0;
            if (trig_valid_o) begin
                nv++;
                if (first_v < 0) first_v = s;
                check("t1_num", int'(trig_num_o), 5);
            end
            if (busy_o) nb++;
        end
        check("t1_first_valid_edge", first_v, 4);
        check("t1_valid_cycles", nv, 1);
        check("t1_busy_cycles", nb, 5);
        check("t1_pending_end", int'(pending_o), 0);

        // Channels 0, 3, 6 together, holdoff 0.
        hard_reset();
        mask_i = 8'hFF; holdoff_i = 0; trig_ready_i = 1'b1; trig_i = 8'h49;
        cnt = 0; prev = 1'b0;
        for (int s = 1; s <= 16; s++) begin
            step();
            if (s == 2) trig_i = '0;
            if (trig_valid_o && !prev) begin
                if (cnt < 3) begin
                    rs[cnt] = s;
                    ns[cnt] = int'(trig_num_o);
                end
                cnt++;
            end
            prev = trig_valid_o;
        end
        check("t2_grant_count", cnt, 3);
        check("t2_order0", ns[0], 0);
        check("t2_order1", ns[1], 3);
        check("t2_order2", ns[2], 6);
        check("t2_first_rise", rs[0], 4);
        check("t2_gap01", rs[1] - rs[0], 2);
        check("t2_gap12", rs[2] - rs[1], 2);

        // Second rise on channel 2 while it is offered but not accepted.
        hard_reset();
        mask_i = 8'hFF; holdoff_i = 0; trig_ready_i = 1'b0;
        pulse(8'h04, 4);
        pulse(8'h04, 4);
        check("t3_lost", int'(lost_o), 8'h04);
        check("t3_valid_held", int'(trig_valid_o), 1);
        check("t3_num_held", int'(trig_num_o), 2);
        trig_ready_i = 1'b1;
        step();
        check("t3_valid_after_accept", int'(trig_valid_o), 0);
        steps(3);

        // Masked channel 0 is ignored; dropping mask[4] clears its pending flag.
        hard_reset();
        mask_i = 8'hFE; holdoff_i = 0; trig_ready_i = 1'b0; nv = 0;
        trig_i = 8'h01;
        for (int s = 1; s <= 8; s++) begin
            step();
            if (s == 2) trig_i = '0;
            if (trig_valid_o) nv++;
        end
        check("t4_masked_valid", nv, 0);
        check("t4_masked_pending", int'(pending_o), 0);
        check("t4_masked_lost", int'(lost_o), 0);
        mask_i = 8'hFF;
        pulse(8'h10, 2);
        check("t4_pending4", int'(pending_o), 8'h10);
        check("t4_offer4", int'(trig_num_o), 4);
        mask_i = 8'hEF;
        step();
        check("t4_pending_cleared", int'(pending_o), 0);
        check("t4_offer_kept", int'(trig_valid_o), 1);
        mask_i = 8'hFF;

        // Reset during a long holdoff, then channel 0 beats channel 7.
        hard_reset();
        mask_i = 8'hFF; holdoff_i = 200; trig_ready_i = 1'b1;
        pulse(8'h08, 6);
        check("t5_in_holdoff_busy", int'(busy_o), 1);
        check("t5_in_holdoff_valid", int'(trig_valid_o), 0);
        trig_i = 8'h81;
        hard_reset();
        first_v = -1; nv = -1;
        for (int s = 1; s <= 8; s++) begin
            step();
            if (trig_valid_o && first_v < 0) begin
                first_v = s;
                nv = int'(trig_num_o);
            end
        end
        check("t5_first_valid_edge", first_v, 4);
        check("t5_winner", nv, 0);
        trig_i = '0;

        // lost_clear alone clears; coinciding with a lost event, set wins.
        hard_reset();
        mask_i = 8'hFF; holdoff_i = 0; trig_ready_i = 1'b0;
        pulse(8'h02, 4);
        pulse(8'h02, 4);
        check("t6_lost_set", int'(lost_o), 8'h02);
        lost_clear_i = 1'b1;
        step();
        lost_clear_i = 1'b0;
        check("t6_lost_cleared", int'(lost_o), 0);
        trig_i = 8'h02;
        steps(2);
        lost_clear_i = 1'b1;
        step();
        lost_clear_i = 1'b0;
        trig_i = '0;
        check("t6_set_wins", int'(lost_o[1]), 1);
        steps(4);

        // Randomized traffic.
        hard_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (cyc == 1500) hard_reset();
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 5) == 0) trig_i[b] = ~trig_i[b];
            mask_i       = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hFF;
            trig_ready_i = ($urandom_range(0, 9) < 7);
            holdoff_i    = HB'($urandom_range(0, 5));
            lost_clear_i = ($urandom_range(0, 15) == 0);
        end
        step();
        check("queue_drain", exp_q.size(), (m_phase == 1) ? 1 : 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
